tt_mux_ctrl: RTL and testbench
==============================

// Module: tt_mux_ctrl
// PURPOSE
// - Parametrised design-select controller and output mux for a tile grid of G_X*G_Y user designs.
// - Sits in tt_top between the Caravel pads and the design tiles. Successor to the fixed single-grid selection:
//   - grid size and reset length are parametric;
//   - adds a power-on per-design reset sequence, select wrap-around and a registered output mux.
// - Control pins are asynchronous to clk. They are synchronised here.
// PARAMETERS
// - G_X       default 8   tile columns
// - G_Y       default 2   tile rows; N = G_X*G_Y designs
// - IO_W      default 8   per-design input and output bus width
// - RST_CYC   default 4   clk cycles the selected design is held in reset after (re)enable; must be >=1
// - ADDR_W    derived     $clog2(G_X*G_Y), minimum 1
// PORTS
// - clk        in   1         system clock (user_clock2 domain)
// - rst_n      in   1         asynchronous, active-low reset
// - sel_rst_ni in   1         async pad; low clears the selection to 0
// - sel_inc_i  in   1         async pad; each rising edge advances the selection by 1
// - ena_i      in   1         async pad; high enables the selected design
// - ui_i       in   IO_W      pad inputs, forwarded to the selected design
// - uo_bus_i   in   N*IO_W    outputs of all designs; design k occupies [k*IO_W +: IO_W]
// - ui_o       out  IO_W      input bus broadcast to the tiles
// - ena_o      out  N         one-hot enable to the tiles
// - des_rst_no out  1         active-low reset to the selected design
// - sel_o      out  ADDR_W    current selection, for debug and LA
// - uo_o       out  IO_W      registered output of the selected design
// BEHAVIOUR
// - Reset values: sel_o=0, ena_o=0, des_rst_no=0, uo_o=0, ui_o=0, FSM=OFF, all synchroniser flops=0.
// - Synchronisers: sel_rst_ni, sel_inc_i and ena_i each pass through 2 flops. Edge detect is done on the sync'd value against a third flop.
// - Selection:
//   - sync sel_rst_n low sets sel=0. It is level-sensitive and beats inc.
//   - otherwise a sync sel_inc rising edge sets sel = (sel==N-1) ? 0 : sel+1.
//   - "sel changed" is a 1-cycle flag, raised only when sel actually changes value.
// - FSM states OFF, RST, RUN:
//   - OFF: ena_o=0, des_rst_no=0. On sync ena=1, go to RST and load cnt=RST_CYC-1.
//   - RST: ena_o=onehot(sel), des_rst_no=0. cnt decrements each cycle; at cnt==0 go to RUN. RST therefore lasts RST_CYC cycles.
//   - RUN: ena_o=onehot(sel), des_rst_no=1.
//   - From RST or RUN, sync ena=0 returns to OFF the next cycle.
//   - From RST or RUN, "sel changed" goes to RST and reloads cnt.
//   - If both happen in the same cycle, ena=0 takes priority.
// - Data path:
//   - ui_o = ui_i, registered with 1-cycle latency, driven in all states.
//   - uo_o <= (state==RUN) ? uo_bus_i[sel*IO_W +: IO_W] : 0, i.e. 1-cycle latency from uo_bus_i.
// - ena_o is never multi-hot. It is all-zero in OFF.
// - Asserting rst_n low mid-operation returns all outputs to their reset values immediately, regardless of clk.
// STRUCTURE
// - Shared package tt_pkg holds:
//   - the state enum {ST_OFF, ST_RST, ST_RUN};
//   - the default G_X, G_Y and IO_W constants;
//   - a clog2-min-1 helper.
// - One sub-module, tt_sync2: a parametrised 2-flop synchroniser with async active-low reset, instanced 3 times.
// - Counter, FSM and mux live in tt_mux_ctrl.
// TESTING
// - T1 reset: rst_n=0 with toggling pads. Required: all outputs 0. Release, then ena_i=1. Required: des_rst_no rises exactly 2+1+RST_CYC cycles after ena_i (2 sync flops, 1 edge flop).
// - T2 wrap: N=16, pulse sel_inc_i 17 times. Required: sel_o returns to 1. After 15 pulses from 0, sel_o=15 and the next pulse gives 0.
// - T3 clear priority: hold sel_rst_ni=0 while pulsing sel_inc_i. Required: sel_o stays 0 and no RST re-entry if sel was already 0.
// - T4 mux: drive uo_bus_i slice k = 8'hA0+k, sel=5, in RUN. Required: uo_o=8'hA5 one cycle later, uo_o=0 in RST and OFF, and ena_o=16'h0020.
// - T5 reselect in RUN: pulse inc. Required: ena_o moves to the new one-hot, des_rst_no is low for RST_CYC cycles, then high.
// - T6 simultaneous: ena_i falls in the same sync cycle as an inc edge. Required: state OFF, sel incremented, ena_o=0.

Source files
------------

// File: rtl/tt_pkg.sv
// Shared definitions for the tile-grid design-select controller: FSM state
// encoding, default grid/bus dimensions and a width helper.
package tt_pkg;

    localparam int G_X_DEF  = 8;
    localparam int G_Y_DEF  = 2;
    localparam int IO_W_DEF = 8;

    // Controller state: tiles off, selected design held in reset, running.
    typedef enum logic [1:0] {
        ST_OFF = 2'd0,
        ST_RST = 2'd1,
        ST_RUN = 2'd2
    } state_t;

    // Number of bits needed to index 'value' items, never less than 1.
    function automatic int clog2_min1(input int value);
        int result;
        if (value <= 2) begin
            result = 1;
        end else begin
            result = $clog2(value);
        end
        return result;
    endfunction

endpackage

// File: rtl/tt_sync2.sv
// Two-flop synchroniser for asynchronous pad inputs.
module tt_sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta_r;
    logic [W-1:0] sync_r;

    // Metastability settling chain; both stages clear to zero on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r <= '0;
            sync_r <= '0;
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/tt_mux_ctrl.sv
// Design-select controller and registered output mux for a G_X*G_Y tile grid.
// Pads are synchronised, the selection counter wraps at N-1, and every
// (re)enable or reselection holds the selected design in reset for RST_CYC
// cycles before it runs.
module tt_mux_ctrl
    import tt_pkg::*;
#(
    parameter  int G_X     = G_X_DEF,
    parameter  int G_Y     = G_Y_DEF,
    parameter  int IO_W    = IO_W_DEF,
    parameter  int RST_CYC = 4,
    localparam int N       = G_X * G_Y,
    localparam int ADDR_W  = clog2_min1(G_X * G_Y)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sel_rst_ni,
    input  logic                sel_inc_i,
    input  logic                ena_i,
    input  logic [IO_W-1:0]     ui_i,
    input  logic [N*IO_W-1:0]   uo_bus_i,
    output logic [IO_W-1:0]     ui_o,
    output logic [N-1:0]        ena_o,
    output logic                des_rst_no,
    output logic [ADDR_W-1:0]   sel_o,
    output logic [IO_W-1:0]     uo_o
);

    localparam int                CNT_W    = clog2_min1(RST_CYC);
    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(RST_CYC - 1);
    localparam logic [ADDR_W-1:0] SEL_LAST = ADDR_W'(N - 1);
    localparam logic [N-1:0]      ONE_N    = N'(1);

    logic              sel_rst_sync_s;
    logic              inc_sync_s;
    logic              ena_sync_s;
    logic              inc_prev_r;
    logic              inc_rise_s;
    logic [ADDR_W-1:0] sel_r;
    logic [ADDR_W-1:0] sel_nxt_s;
    logic              sel_chg_s;
    state_t            state_r;
    state_t            state_nxt_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  cnt_nxt_s;
    logic [N-1:0]      ena_r;
    logic [N-1:0]      ena_nxt_s;
    logic              des_rst_r;
    logic              des_rst_nxt_s;
    logic [IO_W-1:0]   ui_r;
    logic [IO_W-1:0]   uo_r;
    logic [IO_W-1:0]   uo_sel_s;

    tt_sync2 #(.W(1)) u_sync_sel_rst (.clk(clk), .rst_n(rst_n), .d(sel_rst_ni), .q(sel_rst_sync_s));
    tt_sync2 #(.W(1)) u_sync_inc     (.clk(clk), .rst_n(rst_n), .d(sel_inc_i),  .q(inc_sync_s));
    tt_sync2 #(.W(1)) u_sync_ena     (.clk(clk), .rst_n(rst_n), .d(ena_i),      .q(ena_sync_s));

    assign inc_rise_s = inc_sync_s & ~inc_prev_r;

    // Next selection: a held clear beats increment; increment wraps at N-1.
    always_comb begin
        sel_nxt_s = sel_r;
        if (!sel_rst_sync_s) begin
            sel_nxt_s = {ADDR_W{1'b0}};
        end else if (inc_rise_s) begin
            sel_nxt_s = (sel_r == SEL_LAST) ? {ADDR_W{1'b0}} : sel_r + ADDR_W'(1);
        end else begin
            sel_nxt_s = sel_r;
        end
    end

    // Only a real change of value restarts the design reset sequence.
    assign sel_chg_s = (sel_nxt_s != sel_r);

    // Selection register and the increment edge-detect flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_r      <= {ADDR_W{1'b0}};
            inc_prev_r <= 1'b0;
        end else begin
            sel_r      <= sel_nxt_s;
            inc_prev_r <= inc_sync_s;
        end
    end

    // FSM state and reset-length counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_OFF;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // FSM next state: disable wins over reselection, which wins over counting.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        case (state_r)
            ST_OFF: begin
                if (ena_sync_s) begin
                    state_nxt_s = ST_RST;
                    cnt_nxt_s   = CNT_LOAD;
                end else begin
                    state_nxt_s = ST_OFF;
                    cnt_nxt_s   = cnt_r;
                end
            end
            ST_RST: begin
                if (!ena_sync_s) begin
                    state_nxt_s = ST_OFF;
                    cnt_nxt_s   = cnt_r;
                end else if (sel_chg_s) begin
                    state_nxt_s = ST_RST;
                    cnt_nxt_s   = CNT_LOAD;
                end else if (cnt_r == {CNT_W{1'b0}}) begin
                    state_nxt_s = ST_RUN;
                    cnt_nxt_s   = cnt_r;
                end else begin
                    state_nxt_s = ST_RST;
                    cnt_nxt_s   = cnt_r - CNT_W'(1);
                end
            end
            ST_RUN: begin
                if (!ena_sync_s) begin
                    state_nxt_s = ST_OFF;
                    cnt_nxt_s   = cnt_r;
                end else if (sel_chg_s) begin
                    state_nxt_s = ST_RST;
                    cnt_nxt_s   = CNT_LOAD;
                end else begin
                    state_nxt_s = ST_RUN;
                    cnt_nxt_s   = cnt_r;
                end
            end
            default: begin
                state_nxt_s = ST_OFF;
                cnt_nxt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Tile controls for the upcoming state, so the registered copies track state_r.
    always_comb begin
        ena_nxt_s     = {N{1'b0}};
        des_rst_nxt_s = 1'b0;
        case (state_nxt_s)
            ST_OFF: begin
                ena_nxt_s     = {N{1'b0}};
                des_rst_nxt_s = 1'b0;
            end
            ST_RST: begin
                ena_nxt_s     = ONE_N << sel_nxt_s;
                des_rst_nxt_s = 1'b0;
            end
            ST_RUN: begin
                ena_nxt_s     = ONE_N << sel_nxt_s;
                des_rst_nxt_s = 1'b1;
            end
            default: begin
                ena_nxt_s     = {N{1'b0}};
                des_rst_nxt_s = 1'b0;
            end
        endcase
    end

    // Registered tile enable and design reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ena_r     <= {N{1'b0}};
            des_rst_r <= 1'b0;
        end else begin
            ena_r     <= ena_nxt_s;
            des_rst_r <= des_rst_nxt_s;
        end
    end

    // Slice of the currently selected design from the flat output bus.
    always_comb begin
        uo_sel_s = {IO_W{1'b0}};
        for (int k = 0; k < N; k++) begin
            uo_sel_s = (sel_r == ADDR_W'(k)) ? uo_bus_i[k*IO_W +: IO_W] : uo_sel_s;
        end
    end

    // Registered data path: inputs always forwarded, outputs only while running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ui_r <= {IO_W{1'b0}};
            uo_r <= {IO_W{1'b0}};
        end else begin
            ui_r <= ui_i;
            uo_r <= (state_r == ST_RUN) ? uo_sel_s : {IO_W{1'b0}};
        end
    end

    assign ui_o       = ui_r;
    assign ena_o      = ena_r;
    assign des_rst_no = des_rst_r;
    assign sel_o      = sel_r;
    assign uo_o       = uo_r;

endmodule

// File: tb/tb_tt_mux_ctrl.sv
// Directed scoreboard bench for tt_mux_ctrl with default parameters
// (16 designs, 8-bit buses, 4-cycle design reset).
module tb_tt_mux_ctrl;

    localparam int N       = 16;
    localparam int IO_W    = 8;
    localparam int RST_CYC = 4;
    localparam int ADDR_W  = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              sel_rst_ni;
    logic              sel_inc_i;
    logic              ena_i;
    logic [IO_W-1:0]   ui_i;
    logic [N*IO_W-1:0] uo_bus_i;
    logic [IO_W-1:0]   ui_o;
    logic [N-1:0]      ena_o;
    logic              des_rst_no;
    logic [ADDR_W-1:0] sel_o;
    logic [IO_W-1:0]   uo_o;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    tt_mux_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sel_rst_ni (sel_rst_ni),
        .sel_inc_i  (sel_inc_i),
        .ena_i      (ena_i),
        .ui_i       (ui_i),
        .uo_bus_i   (uo_bus_i),
        .ui_o       (ui_o),
        .ena_o      (ena_o),
        .des_rst_no (des_rst_no),
        .sel_o      (sel_o),
        .uo_o       (uo_o)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic pop_check(input logic [31:0] obs);
        exp_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL scoreboard_empty: observed=%0h expected=<none>", obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e.val) else begin
                bad++;
                $error("FAIL %s: observed=%0h expected=%0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic pulse_inc();
        sel_inc_i = 1'b1;
        tick(3);
        sel_inc_i = 1'b0;
        tick(3);
    endtask

    initial begin
        int n;
        int low_cnt;
        bit seen;

        // T1: reset with toggling pads
        rst_n      = 1'b0;
        sel_rst_ni = 1'b1;
        sel_inc_i  = 1'b0;
        ena_i      = 1'b0;
        ui_i       = 8'h00;
        for (int k = 0; k < N; k++) uo_bus_i[k*IO_W +: IO_W] = 8'hA0 + 8'(k);
        for (int i = 0; i < 6; i++) begin
            sel_inc_i = ~sel_inc_i;
            ena_i     = ~ena_i;
            ui_i      = ui_i + 8'h11;
            tick(1);
        end
        push("rst_outputs", 32'h0);
        pop_check(32'({ui_o, ena_o, des_rst_no, sel_o, uo_o}));

        sel_inc_i = 1'b0;
        ena_i     = 1'b0;
        ui_i      = 8'h00;
        rst_n     = 1'b1;
        tick(5);

        ena_i = 1'b1;
        push("ena_to_run_latency", 32'(2 + 1 + RST_CYC));
        n = 0;
        seen = 1'b0;
        for (int i = 1; i <= 20 && !seen; i++) begin
            tick(1);
            if (des_rst_no) begin
                n = i;
                seen = 1'b1;
            end
        end
        pop_check(32'(n));
        push("ena_onehot_sel0", 32'h0001);
        pop_check(32'(ena_o));

        ui_i = 8'h5A;
        push("ui_forward", 32'h5A);
        tick(1);
        pop_check(32'(ui_o));

        // T2: wrap-around
        for (int i = 0; i < 15; i++) pulse_inc();
        push("sel_after_15", 32'd15);
        pop_check(32'(sel_o));
        pulse_inc();
        push("sel_wrap_0", 32'd0);
        pop_check(32'(sel_o));
        pulse_inc();
        push("sel_after_17", 32'd1);
        pop_check(32'(sel_o));

        // T3: clear beats increment, no RST re-entry when already 0
        sel_rst_ni = 1'b0;
        tick(12);
        push("clear_sel", 32'd0);
        pop_check(32'(sel_o));
        push("clear_running", 32'd1);
        pop_check(32'(des_rst_no));
        low_cnt = 0;
        for (int p = 0; p < 3; p++) begin
            sel_inc_i = 1'b1;
            for (int i = 0; i < 3; i++) begin
                tick(1);
                if (!des_rst_no) low_cnt++;
            end
            sel_inc_i = 1'b0;
            for (int i = 0; i < 3; i++) begin
                tick(1);
                if (!des_rst_no) low_cnt++;
            end
        end
        push("clear_hold_sel", 32'd0);
        pop_check(32'(sel_o));
        push("clear_no_rst_reentry", 32'd0);
        pop_check(32'(low_cnt));
        sel_rst_ni = 1'b1;
        tick(4);

        // T4: output mux with sel=5
        for (int i = 0; i < 5; i++) pulse_inc();
        push("uo_in_rst", 32'h0);
        pop_check(32'(uo_o));
        push("des_rst_in_rst", 32'h0);
        pop_check(32'(des_rst_no));
        tick(3);
        push("ena_onehot_sel5", 32'h0020);
        pop_check(32'(ena_o));
        push("uo_sel5", 32'hA5);
        pop_check(32'(uo_o));
        uo_bus_i[5*IO_W +: IO_W] = 8'h3C;
        push("uo_latency_old", 32'hA5);
        pop_check(32'(uo_o));
        push("uo_latency_new", 32'h3C);
        tick(1);
        pop_check(32'(uo_o));
        uo_bus_i[5*IO_W +: IO_W] = 8'hA5;

        ena_i = 1'b0;
        tick(5);
        push("uo_in_off", 32'h0);
        pop_check(32'(uo_o));
        push("ena_in_off", 32'h0);
        pop_check(32'(ena_o));
        ena_i = 1'b1;
        tick(12);

        // T5: reselect while running
        sel_inc_i = 1'b1;
        tick(3);
        sel_inc_i = 1'b0;
        push("reselect_onehot", 32'h0040);
        pop_check(32'(ena_o));
        low_cnt = 0;
        for (int i = 0; i < 20 && !des_rst_no; i++) begin
            low_cnt++;
            tick(1);
        end
        push("reselect_rst_len", 32'(RST_CYC));
        pop_check(32'(low_cnt));
        push("reselect_running", 32'd1);
        pop_check(32'(des_rst_no));
        tick(3);

        // T6: disable and increment in the same sync cycle
        ena_i     = 1'b0;
        sel_inc_i = 1'b1;
        tick(5);
        sel_inc_i = 1'b0;
        push("simul_sel", 32'd7);
        pop_check(32'(sel_o));
        push("simul_ena_off", 32'h0);
        pop_check(32'(ena_o));
        push("simul_des_rst", 32'h0);
        pop_check(32'(des_rst_no));
        push("simul_uo", 32'h0);
        pop_check(32'(uo_o));

        // Asynchronous reset in the middle of operation
        ena_i = 1'b1;
        tick(12);
        push("pre_rst_uo", 32'hA7);
        pop_check(32'(uo_o));
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        push("async_rst_outputs", 32'h0);
        pop_check(32'({ui_o, ena_o, des_rst_no, sel_o, uo_o}));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
